// File: rtl/vga_pkg.sv
// Shared timing constants and types for the 640x480@60 VGA controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_pkg;

    localparam int H_SYNC      = 96;
    localparam int H_ACT_START = 144;
    localparam int H_ACT_END   = 783;
    localparam int H_TOTAL     = 800;

    localparam int V_SYNC      = 2;
    localparam int V_ACT_START = 35;
    localparam int V_ACT_END   = 514;
    localparam int V_TOTAL     = 525;

    localparam int ADDR_W = 10;
    localparam int RGB_W  = 8;

    // Undelayed sync/blank bundle carried through the delay line.
    // Inactive value is {hs=1, vs=1, vld=0} = 3'b110.
    typedef struct packed {
        logic hs;
        logic vs;
        logic vld;
    } sync_t;

endpackage

// File: rtl/vga_ctrl_if.sv
// Bus between the VGA timing/output stage and the picture-fetch stage plus DAC pins.
// Latency: n/a (wires only).
// Backpressure: none; the pixel stream is free-running.
// master: timing generator (drives addresses, sync, rgb; reads data).
// slave : fetch stage / pins (drives data; reads everything else).
interface vga_ctrl_if #(
    parameter int FCNT_W = 8
);
    import vga_pkg::*;

    logic [23:0]       data;
    logic [ADDR_W-1:0] h_addr;
    logic [ADDR_W-1:0] v_addr;
    logic              valid;
    logic              hsync;
    logic              vsync;
    logic              blank_n;
    logic [RGB_W-1:0]  vga_r;
    logic [RGB_W-1:0]  vga_g;
    logic [RGB_W-1:0]  vga_b;
    logic              frame_start;
    logic [FCNT_W-1:0] frame_cnt;

    modport master (
        input  data,
        output h_addr, v_addr, valid, hsync, vsync, blank_n,
        output vga_r, vga_g, vga_b, frame_start, frame_cnt
    );

    modport slave (
        output data,
        input  h_addr, v_addr, valid, hsync, vsync, blank_n,
        input  vga_r, vga_g, vga_b, frame_start, frame_cnt
    );

endinterface

// File: rtl/vga_ctrl_sig_delay.sv
// Fixed-depth shift register used to align sync/blank with the fetch-path latency.
// Latency: DEPTH cycles (DEPTH=0 is a combinational pass-through).
// Backpressure: none; shifts every cycle.
// Ports: clk, rst_n (sync, active low, loads RESET_VAL into every stage), din, dout.
module sig_delay #(
    parameter int                 WIDTH     = 3,
    parameter int                 DEPTH     = 2,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage[i] <= RESET_VAL;
                    end
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_ctrl.sv
// 640x480@60 VGA timing generator and DAC output stage.
// Latency: addresses/valid/frame_start are 0-cycle from the counters; sync/blank delayed by PIPE.
// Backpressure: none; runs every pixel clock, data must arrive PIPE cycles after its address.
// Ports: clk_div (pixel clock), clrn (sync active-low reset), bus (vga_ctrl_if.master).
module vga_ctrl
    import vga_pkg::*;
#(
    parameter int PIPE   = 2,
    parameter int FCNT_W = 8
) (
    input  logic           clk_div,
    input  logic           clrn,
    vga_ctrl_if.master     bus
);

    logic [ADDR_W-1:0] h_cnt;
    logic [ADDR_W-1:0] v_cnt;
    logic [FCNT_W-1:0] fcnt;

    logic  h_end;
    logic  v_end;
    logic  act_vld;
    sync_t raw;
    sync_t dly;

    assign h_end = (h_cnt == ADDR_W'(H_TOTAL - 1));
    assign v_end = (v_cnt == ADDR_W'(V_TOTAL - 1));

    always_ff @(posedge clk_div) begin
        if (!clrn) begin
            h_cnt <= '0;
            v_cnt <= '0;
            fcnt  <= '0;
        end else begin
            h_cnt <= h_end ? '0 : h_cnt + 1'b1;
            if (h_end) begin
                v_cnt <= v_end ? '0 : v_cnt + 1'b1;
            end
            // Frame completes on the last pixel of the last line.
            if (h_end && v_end) begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    assign act_vld = (h_cnt >= ADDR_W'(H_ACT_START)) && (h_cnt <= ADDR_W'(H_ACT_END)) &&
                     (v_cnt >= ADDR_W'(V_ACT_START)) && (v_cnt <= ADDR_W'(V_ACT_END));

    assign raw.hs  = (h_cnt >= ADDR_W'(H_SYNC));
    assign raw.vs  = (v_cnt >= ADDR_W'(V_SYNC));
    assign raw.vld = act_vld;

    // Sync/blank are delayed to line up with the pixel the fetch stage returns;
    // reset flushes every stage to the inactive pattern so no stale pixel leaks out.
    sig_delay #(
        .WIDTH     (3),
        .DEPTH     (PIPE),
        .RESET_VAL (3'b110)
    ) u_dly (
        .clk   (clk_div),
        .rst_n (clrn),
        .din   (raw),
        .dout  (dly)
    );

    assign bus.h_addr      = act_vld ? h_cnt - ADDR_W'(H_ACT_START) : '0;
    assign bus.v_addr      = act_vld ? v_cnt - ADDR_W'(V_ACT_START) : '0;
    assign bus.valid       = act_vld;
    assign bus.frame_start = (h_cnt == '0) && (v_cnt == '0);
    assign bus.frame_cnt   = fcnt;

    assign bus.hsync   = dly.hs;
    assign bus.vsync   = dly.vs;
    assign bus.blank_n = dly.vld;

    assign bus.vga_r = dly.vld ? bus.data[23:16] : '0;
    assign bus.vga_g = dly.vld ? bus.data[15:8]  : '0;
    assign bus.vga_b = dly.vld ? bus.data[7:0]   : '0;

endmodule

// File: tb/tb_vga_ctrl.sv
// Self-checking bench for vga_ctrl: frame-position model plus directed literal checks.
module tb_vga_ctrl;
    import vga_pkg::*;

    localparam int PIPE = 2;

    logic clk_div = 1'b0;
    logic clrn    = 1'b0;

    vga_ctrl_if #(.FCNT_W(8)) bus ();

    vga_ctrl #(.PIPE(PIPE), .FCNT_W(8)) dut (
        .clk_div (clk_div),
        .clrn    (clrn),
        .bus     (bus)
    );

    always #20 clk_div = ~clk_div;

    int tests = 0;
    int fails = 0;

    // ---------------- model: position in the frame from a cycle index ----------
    typedef struct {
        bit hs;
        bit vs;
        bit vld;
        int ha;
        int va;
    } pix_t;

    longint t     = 0;   // cycles since counters were last (0,0) from reset
    int     fbase = 0;   // frame count at t=0
    pix_t   hist[$];     // undelayed values, newest first
    bit     chk_on = 1'b0;

    function automatic pix_t undel(longint tt);
        pix_t p;
        int h, v;
        h = int'(tt % 800);
        v = int'((tt / 800) % 525);
        p.vld = (h >= 144) && (h < 784) && (v >= 35) && (v < 515);
        p.ha  = p.vld ? h - 144 : 0;
        p.va  = p.vld ? v - 35 : 0;
        p.hs  = (h >= 96);
        p.vs  = (v >= 2);
        return p;
    endfunction

    function automatic pix_t inactive();
        pix_t p;
        p.hs = 1; p.vs = 1; p.vld = 0; p.ha = 0; p.va = 0;
        return p;
    endfunction

    function automatic pix_t tap();
        if (PIPE == 0) return undel(t);
        return hist[PIPE-1];
    endfunction

    function automatic logic [23:0] exp_rgb();
        pix_t d;
        logic [31:0] a, b;
        d = tap();
        a = d.ha;
        b = d.va;
        return d.vld ? {a[7:0], b[7:0], 8'hA5} : 24'h0;
    endfunction

    always @(posedge clk_div) begin
        if (!clrn) begin
            t = 0;
            fbase = 0;
            hist.delete();
            for (int i = 0; i < PIPE; i++) hist.push_front(inactive());
        end else begin
            if (PIPE > 0) begin
                hist.push_front(undel(t));
                void'(hist.pop_back());
            end
            t++;
        end
    end

    // ---------------- fetch-stage stand-in: data = f(address PIPE cycles ago) ---
    typedef struct {
        bit         vld;
        logic [7:0] h;
        logic [7:0] v;
    } rec_t;
    rec_t rec[$];

    initial bus.data = 24'hFFFFFF;

    always @(negedge clk_div) begin
        rec_t r;
        #3;
        r.vld = bus.valid;
        r.h   = bus.h_addr[7:0];
        r.v   = bus.v_addr[7:0];
        rec.push_front(r);
        while (rec.size() > PIPE) void'(rec.pop_back());
    end

    always @(posedge clk_div) begin
        rec_t r;
        #1;
        if (PIPE > 0 && rec.size() >= PIPE) begin
            r = rec[PIPE-1];
            bus.data = r.vld ? {r.h, r.v, 8'hA5} : 24'hFFFFFF;
        end else begin
            bus.data = 24'hFFFFFF;
        end
    end

    // ---------------- per-cycle compare + sync measurements --------------------
    bit     meas_on   = 1'b0;
    bit     prev_hs   = 1'b1;
    longint last_fall = -1;
    longint hs_period = 0;
    int     vs_low    = 0;

    always @(negedge clk_div) begin
        pix_t        c, d;
        logic [56:0] got, expv;
        logic [31:0] ha, va;
        logic [7:0]  fc;
        if (chk_on) begin
            c  = undel(t);
            d  = tap();
            ha = c.ha;
            va = c.va;
            fc = 8'((fbase + t / 420000) % 256);
            expv = {ha[9:0], va[9:0], c.vld, (t % 420000 == 0), fc,
                    d.hs, d.vs, d.vld, exp_rgb()};
            got  = {bus.h_addr, bus.v_addr, bus.valid, bus.frame_start, bus.frame_cnt,
                    bus.hsync, bus.vsync, bus.blank_n, bus.vga_r, bus.vga_g, bus.vga_b};
            tests++;
            if (got !== expv) begin
                fails++;
                $display("FAIL cycle t=%0d outputs got=%h exp=%h", t, got, expv);
            end
            if (meas_on) begin
                if (prev_hs && !bus.hsync) begin
                    if (last_fall >= 0) hs_period = t - last_fall;
                    last_fall = t;
                end
                if (!bus.vsync) vs_low++;
            end
            prev_hs = bus.hsync;
        end
    end

    // ---------------- directed checks ------------------------------------------
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, expv);
        end
    endtask

    task automatic go_to(input longint target);
        if (target < t) begin
            tests++;
            fails++;
            $display("FAIL go_to target=%0d already at t=%0d", target, t);
        end else begin
            repeat (int'(target - t)) @(negedge clk_div);
        end
    endtask

    // Teleport the counters to (h, v) with frame count f; called at a negedge.
    task automatic jump(input int h, input int v, input int f);
        meas_on = 1'b0;
        #1;
        force dut.h_cnt = 10'(h);
        force dut.v_cnt = 10'(v);
        force dut.fcnt  = 8'(f);
        #1;
        release dut.h_cnt;
        release dut.v_cnt;
        release dut.fcnt;
        t     = longint'(v) * 800 + h;
        fbase = f;
    endtask

    initial begin
        clrn = 1'b0;
        @(negedge clk_div);
        chk_on = 1'b1;
        chk("rst_h_addr",  32'(bus.h_addr), 0);
        chk("rst_valid",   32'(bus.valid), 0);
        chk("rst_hsync",   32'(bus.hsync), 1);
        chk("rst_vsync",   32'(bus.vsync), 1);
        chk("rst_blank_n", 32'(bus.blank_n), 0);
        chk("rst_rgb",     32'({bus.vga_r, bus.vga_g, bus.vga_b}), 0);
        repeat (4) @(negedge clk_div);
        clrn = 1'b1;
        meas_on = 1'b1;
        chk("release_frame_start", 32'(bus.frame_start), 1);

        go_to(1);  chk("hsync_t1",  32'(bus.hsync), 1);
        go_to(2);  chk("hsync_t2",  32'(bus.hsync), 0);
        go_to(97); chk("hsync_t97", 32'(bus.hsync), 0);
        go_to(98); chk("hsync_t98", 32'(bus.hsync), 1);
        go_to(100);
        chk("blank_rgb_zero", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 0);
        chk("blank_data_ff",  32'(bus.data), 32'hFFFFFF);
        go_to(2000);
        chk("hsync_period", 32'(hs_period), 800);
        chk("vsync_low_len", 32'(vs_low), 1600);

        go_to(28144);
        chk("first_row_valid", 32'(bus.valid), 1);
        chk("first_row_addr",  32'({bus.h_addr, bus.v_addr}), 0);
        go_to(28783);
        chk("row_end_h_addr", 32'(bus.h_addr), 639);
        go_to(28784);
        chk("row_end_valid", 32'(bus.valid), 0);

        go_to(40 * 800 + 144 + 3 + PIPE);
        chk("pix35_rgb",     32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'h0305A5);
        chk("pix35_blank_n", 32'(bus.blank_n), 1);
        chk("pix35_model",   32'(exp_rgb()), 32'h0305A5);

        jump(770, 514, 0);
        go_to(514 * 800 + 783);
        chk("last_row_v_addr", 32'(bus.v_addr), 479);
        chk("last_row_h_addr", 32'(bus.h_addr), 639);
        go_to(514 * 800 + 784);
        chk("last_row_end_valid", 32'(bus.valid), 0);

        jump(780, 524, 255);
        go_to(419999);
        chk("fcnt_before_wrap", 32'(bus.frame_cnt), 255);
        go_to(420000);
        chk("fcnt_wrapped",     32'(bus.frame_cnt), 0);
        chk("wrap_frame_start", 32'(bus.frame_start), 1);

        jump(390, 200, 0);
        go_to(200 * 800 + 400);
        clrn = 1'b0;
        @(negedge clk_div);
        clrn = 1'b1;
        chk("midrst_addr",  32'({bus.h_addr, bus.v_addr}), 0);
        chk("midrst_hsync", 32'(bus.hsync), 1);
        chk("midrst_rgb",   32'({bus.vga_r, bus.vga_g, bus.vga_b}), 0);
        chk("midrst_fcnt",  32'(bus.frame_cnt), 0);
        go_to(1); chk("midrst_hsync_t1", 32'(bus.hsync), 1);
        go_to(2); chk("midrst_hsync_t2", 32'(bus.hsync), 0);
        go_to(900);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
